// File: rtl/expr_pkg.sv
// Shared constants, state encoding and LFSR helpers for the expression transmitter.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StDigit = 2'b01,
    StOp    = 2'b10
  } state_e;

  // Feedback is the parity of taps 7,5,4,3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] digit_char(input logic [7:0] v);
    logic [3:0] d;
    d = v[3:0];
    if (d >= 4'd10) d = d - 4'd10;
    return CH_0 + {4'h0, d};
  endfunction

  function automatic logic [7:0] op_char(input logic [7:0] v);
    return v[4] ? CH_STAR : CH_PLUS;
  endfunction

endpackage

// File: rtl/expr_tx_if.sv
// Character stream from the expression transmitter to its consumer.
interface expr_tx_if;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_char,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_char,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/expr_lfsr8.sv
// 8-bit Fibonacci LFSR with zero-fixing load and advance enable.
module expr_lfsr8
  import expr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       adv_i,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_d, lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      // All-zero is the lock-up state, so never load it.
      lfsr_d = (seed_i == 8'h00) ? LFSR_SEED : seed_i;
    end else if (adv_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/expr_tx.sv
// Pseudo-random "digit (op digit)*" expression generator, one character per handshake.
// Optional EXPR_TX_ERR_INJ_EN adds inj_err, which appends one illegal trailing operator.
module expr_tx
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic [3:0] terms,
  input  logic [7:0] seed,
`ifdef EXPR_TX_ERR_INJ_EN
  input  logic       inj_err,
`endif
  output logic       busy,
  expr_tx_if.master  tx
);

  localparam int unsigned RemW = $clog2(MAX_TERMS + 1);

  state_e          state_d, state_q;
  logic [RemW-1:0] rem_d, rem_q;
  logic            inj_q;
  logic            lfsr_load, lfsr_adv;
  logic [7:0]      lfsr;
  logic            hs;

  function automatic logic [RemW-1:0] clamp_terms(input logic [3:0] t);
    int unsigned n;
    n = int'(t);
    if (n == 0) n = 1;
    if (n > MAX_TERMS) n = MAX_TERMS;
    return RemW'(n);
  endfunction

`ifdef EXPR_TX_ERR_INJ_EN
  logic inj_d;

  always_comb begin
    inj_d = inj_q;
    if (state_q == StIdle && start) inj_d = inj_err;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      inj_q <= 1'b0;
    end else begin
      inj_q <= inj_d;
    end
  end
`else
  assign inj_q = 1'b0;
`endif

  assign hs = tx.out_valid & tx.out_ready;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    lfsr_load    = 1'b0;
    lfsr_adv     = 1'b0;
    tx.out_valid = 1'b0;
    tx.out_last  = 1'b0;
    tx.out_char  = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d     = clamp_terms(terms);
          lfsr_load = 1'b1;
          state_d   = StDigit;
        end
      end
      StDigit: begin
        tx.out_valid = 1'b1;
        tx.out_char  = digit_char(lfsr);
        tx.out_last  = (rem_q == RemW'(1)) && !inj_q;
        if (hs) begin
          rem_d    = rem_q - RemW'(1);
          lfsr_adv = 1'b1;
          state_d  = tx.out_last ? StIdle : StOp;
        end
      end
      StOp: begin
        tx.out_valid = 1'b1;
        tx.out_char  = op_char(lfsr);
        // rem reaches zero in OP only for the injected trailing operator.
        tx.out_last  = (rem_q == '0);
        if (hs) begin
          lfsr_adv = 1'b1;
          state_d  = tx.out_last ? StIdle : StDigit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  assign busy = (state_q != StIdle);

  expr_lfsr8 u_lfsr (
    .clk_i  (clk),
    .rst_ni (clr_n),
    .load_i (lfsr_load),
    .seed_i (seed),
    .adv_i  (lfsr_adv),
    .lfsr_o (lfsr)
  );

endmodule

// File: tb/tb_expr_tx.sv
// Randomized bench for expr_tx against a queue-based reference model of the character stream.
module tb_expr_tx;

  localparam int unsigned MaxTerms = 8;
`ifdef EXPR_TX_ERR_INJ_EN
  localparam bit InjEn = 1'b1;
`else
  localparam bit InjEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic [3:0] terms;
  logic [7:0] seed;
  logic       inj_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  expr_tx_if tx ();

  always #5 clk = ~clk;

  expr_tx #(
    .MAX_TERMS (MaxTerms)
  ) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .terms   (terms),
    .seed    (seed),
`ifdef EXPR_TX_ERR_INJ_EN
    .inj_err (inj_err),
`endif
    .busy    (busy),
    .tx      (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: emit N digits separated by operators, stepping the LFSR after each character.
  function automatic void build_expr(input int unsigned t, input logic [7:0] s, input bit inj,
                                     output byte q[$]);
    int unsigned n;
    logic [7:0]  r;
    q = {};
    n = (t == 0) ? 1 : ((t > MaxTerms) ? MaxTerms : t);
    r = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < int'(n); i++) begin
      q.push_back(byte'(8'h30 + (r[3:0] % 10)));
      r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
      if (i < int'(n) - 1 || (inj && InjEn)) begin
        q.push_back(byte'(r[4] ? 8'h2A : 8'h2B));
        r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
      end
    end
  endfunction

  task automatic run_expr(input int unsigned t, input logic [7:0] s, input bit inj,
                          input int stall_pct, input int hold_idx, input int hold_n,
                          input bit dup_start);
    byte        q[$];
    int         acc = 0;
    int         held = 0;
    int         cyc = 0;
    bit         prev_stall = 1'b0;
    bit         pulsed = 1'b0;
    logic       rdy;
    logic [7:0] prev_char = 8'h00;
    build_expr(t, s, inj, q);
    @(negedge clk);
    start = 1'b1; terms = 4'(t); seed = s; inj_err = inj; tx.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (acc < q.size() && cyc < 400) begin
      start = 1'b0;
      if (!tx.out_valid) begin
        check("valid_mid_expr", 32'(tx.out_valid), 32'd1);
        break;
      end
      if (prev_stall) check("hold_char", 32'(tx.out_char), 32'(prev_char));
      if (acc == hold_idx && held < hold_n) begin
        rdy = 1'b0; held++;
      end else begin
        rdy = !(stall_pct > 0 && $urandom_range(99) < stall_pct);
      end
      tx.out_ready = rdy;
      prev_char = tx.out_char;
      if (rdy) begin
        check("char", 32'(tx.out_char), 32'(q[acc]));
        check("last", 32'(tx.out_last), 32'(acc == q.size() - 1));
        acc++;
      end
      prev_stall = !rdy;
      if (dup_start && acc == 2 && !pulsed) begin
        start = 1'b1; terms = 4'd2; pulsed = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tx.out_ready = 1'b0;
    if (acc < q.size()) check("char_count", 32'(acc), 32'(q.size()));
    check("idle_valid", 32'(tx.out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    // A duplicated start must not have launched a second expression.
    @(negedge clk);
    check("no_restart", 32'(tx.out_valid), 32'd0);
  endtask

  initial begin
    clr_n = 1'b1; start = 1'b0; terms = 4'd0; seed = 8'h00; inj_err = 1'b0;
    tx.out_ready = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    check("rst_valid", 32'(tx.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last", 32'(tx.out_last), 32'd0);
    check("rst_char", 32'(tx.out_char), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;

    run_expr(3, 8'h01, 1'b0, 0, -1, 0, 1'b0);
    run_expr(0, 8'h00, 1'b0, 0, -1, 0, 1'b0);
    run_expr(15, 8'($urandom), 1'b0, 0, -1, 0, 1'b0);
    run_expr(3, 8'h01, 1'b0, 0, 1, 3, 1'b0);
    run_expr(4, 8'h5A, 1'b0, 0, -1, 0, 1'b1);

    // Asynchronous abort on the third character.
    @(negedge clk);
    start = 1'b1; terms = 4'd5; seed = 8'h37; tx.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_valid", 32'(tx.out_valid), 32'd1);
    #2 clr_n = 1'b0;
    #1;
    check("abort_valid", 32'(tx.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_char", 32'(tx.out_char), 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_abort_valid", 32'(tx.out_valid), 32'd0);
    check("post_abort_busy", 32'(busy), 32'd0);
    tx.out_ready = 1'b0;

`ifdef EXPR_TX_ERR_INJ_EN
    run_expr(2, 8'h01, 1'b1, 0, -1, 0, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      run_expr($urandom_range(15), 8'($urandom), 1'($urandom), 30, -1, 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
